// File: rtl/pipelined_cpu_pkg.sv
// pipelined_cpu_pkg: shared encodings, ALU controls and pipeline register layouts for pipelined_cpu.
package pipelined_cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        alu_op_t alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } id_ex_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] result;
        logic [4:0]  rd;
    } mem_wb_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/pipelined_cpu_alu.sv
// pipelined_cpu_alu: 32-bit wrap-around ALU; the multiplier exists only with PIPELINED_CPU_MUL_EN.
module pipelined_cpu_alu
    import pipelined_cpu_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        case (op)
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRA: y = $unsigned($signed(a) >>> b[4:0]);
`ifdef PIPELINED_CPU_MUL_EN
            ALU_MUL: y = a * b;
`endif
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/pipelined_cpu.sv
// pipelined_cpu: 5-stage RV32 subset pipeline with forwarding, load-use stall and ID-resolved beq (mul via PIPELINED_CPU_MUL_EN).
module pipelined_cpu
    import pipelined_cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32
) (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] imem    [0:IMEM_WORDS-1];
    logic [31:0] dmem    [0:DMEM_WORDS-1];
    logic [31:0] regfile [0:31];

    logic [31:0] pc_q;
    if_id_t      if_id, fetch;
    id_ex_t      id_ex, dec;
    ex_mem_t     ex_mem, ex_mem_n;
    mem_wb_t     mem_wb, mem_wb_n;

    logic        stall, flush, beq_d, taken, wb_we;
    logic [31:0] target, fwd_a, fwd_b, alu_y;
    logic [DAW-1:0] daddr;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;

    assign fetch  = '{pc: pc_q, instr: imem[pc_q[IAW+1:2]]};
    assign opcode = if_id.instr[6:0];
    assign f3     = if_id.instr[14:12];
    assign f7     = if_id.instr[31:25];
    assign wb_we  = mem_wb.ctrl.reg_write && mem_wb.rd != 5'd0;

    always_comb begin
        dec       = '0;
        beq_d     = 1'b0;
        dec.rs1   = if_id.instr[19:15];
        dec.rs2   = if_id.instr[24:20];
        dec.rd    = if_id.instr[11:7];
        case (opcode)
            OP_R: begin
                dec.ctrl.reg_write = 1'b1;
                case ({f7, f3})
                    {F7_BASE, F3_ADD}: dec.ctrl.alu_op = ALU_ADD;
                    {F7_ALT,  F3_ADD}: dec.ctrl.alu_op = ALU_SUB;
                    {F7_BASE, F3_SLL}: dec.ctrl.alu_op = ALU_SLL;
                    {F7_BASE, F3_XOR}: dec.ctrl.alu_op = ALU_XOR;
                    {F7_BASE, F3_AND}: dec.ctrl.alu_op = ALU_AND;
`ifdef PIPELINED_CPU_MUL_EN
                    {F7_MUL,  F3_ADD}: dec.ctrl.alu_op = ALU_MUL;
`endif
                    default:           dec.ctrl.reg_write = 1'b0;
                endcase
            end
            OP_I: begin
                if (f3 == F3_ADD || (f3 == F3_SR && f7 == F7_ALT)) begin
                    dec.ctrl.reg_write = 1'b1;
                    dec.ctrl.alu_src   = 1'b1;
                    dec.ctrl.alu_op    = f3 == F3_SR ? ALU_SRA : ALU_ADD;
                    dec.imm            = sext12(if_id.instr[31:20]);
                end
            end
            OP_LOAD: begin
                if (f3 == F3_W) begin
                    dec.ctrl.reg_write = 1'b1;
                    dec.ctrl.mem_read  = 1'b1;
                    dec.ctrl.alu_src   = 1'b1;
                    dec.imm            = sext12(if_id.instr[31:20]);
                end
            end
            OP_STORE: begin
                if (f3 == F3_W) begin
                    dec.ctrl.mem_write = 1'b1;
                    dec.ctrl.alu_src   = 1'b1;
                    dec.imm            = sext12({if_id.instr[31:25], if_id.instr[11:7]});
                end
            end
            OP_BRANCH: begin
                if (f3 == F3_BEQ) begin
                    beq_d   = 1'b1;
                    dec.imm = {{20{if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                               if_id.instr[30:25], if_id.instr[11:8]};
                end
            end
            default: ;
        endcase
        // WB result is bypassed so a same-cycle write is visible to ID reads
        dec.rd1 = (wb_we && mem_wb.rd == dec.rs1) ? mem_wb.result : regfile[dec.rs1];
        dec.rd2 = (wb_we && mem_wb.rd == dec.rs2) ? mem_wb.result : regfile[dec.rs2];
    end

    assign stall  = id_ex.ctrl.mem_read && id_ex.rd != 5'd0 &&
                    (id_ex.rd == dec.rs1 || id_ex.rd == dec.rs2);
    assign taken  = beq_d && dec.rd1 == dec.rd2;
    assign flush  = taken && !stall;
    assign target = if_id.pc + (dec.imm << 1);

    assign fwd_a = (ex_mem.ctrl.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1) ? ex_mem.result :
                   (wb_we && mem_wb.rd == id_ex.rs1) ? mem_wb.result : id_ex.rd1;
    assign fwd_b = (ex_mem.ctrl.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2) ? ex_mem.result :
                   (wb_we && mem_wb.rd == id_ex.rs2) ? mem_wb.result : id_ex.rd2;

    pipelined_cpu_alu u_alu (
        .op (id_ex.ctrl.alu_op),
        .a  (fwd_a),
        .b  (id_ex.ctrl.alu_src ? id_ex.imm : fwd_b),
        .y  (alu_y)
    );

    assign ex_mem_n = '{ctrl: id_ex.ctrl, result: alu_y, store_data: fwd_b, rd: id_ex.rd};
    assign daddr    = ex_mem.result[DAW+1:2];
    assign mem_wb_n = '{ctrl: ex_mem.ctrl, rd: ex_mem.rd,
                        result: ex_mem.ctrl.mem_read ? dmem[daddr] : ex_mem.result};

    // start_i=0 freezes the whole pipeline so in-flight work resumes intact
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q   <= '0;
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else if (start_i) begin
            ex_mem <= ex_mem_n;
            mem_wb <= mem_wb_n;
            if (stall) begin
                id_ex <= '0;
            end else begin
                id_ex <= dec;
                if_id <= flush ? '0 : fetch;
                pc_q  <= flush ? target : pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && start_i && ex_mem.ctrl.mem_write)
            dmem[daddr] <= ex_mem.store_data;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && start_i && wb_we)
            regfile[mem_wb.rd] <= mem_wb.result;
    end

    logic unused_bits;
    assign unused_bits = ^{pc_q[1:0], pc_q[31:IAW+2], ex_mem.result[1:0],
                           ex_mem.result[31:DAW+2], ex_mem.ctrl, mem_wb.ctrl};

endmodule

// File: tb/tb_pipelined_cpu.sv
// tb_pipelined_cpu: directed programs; expected register writebacks are queued and checked by a WB monitor.
module tb_pipelined_cpu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int stalls = 0;
    int flushes = 0;
    logic        pc_chk = 1'b0;
    logic [31:0] br_target = '0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_cpu dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return i_t(imm, rs1, 3'b000, rd, 7'h13);
    endfunction

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'h63};
    endfunction

    always @(negedge clk) begin
        if (!rst && start && dut.mem_wb.ctrl.reg_write && dut.mem_wb.rd != 5'd0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wb_unexpected: got x%0d=%h, expected no write", dut.mem_wb.rd, dut.mem_wb.result);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wb_rd", {27'b0, dut.mem_wb.rd}, {27'b0, e[36:32]});
                chk("wb_data", dut.mem_wb.result, e[31:0]);
            end
        end
    end

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    task automatic begin_test();
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) dut.imem[i] = '0;
        for (int i = 0; i < 32; i++) dut.dmem[i] = '0;
        for (int i = 0; i < 32; i++) dut.regfile[i] = '0;
        exp_q.delete();
        stalls = 0;
        flushes = 0;
        pc_chk = 1'b0;
    endtask

    task automatic run(input int n);
        rst = 1'b0;
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pc_chk) chk("pc_after_flush", dut.pc_q, br_target);
            pc_chk = dut.flush;
            stalls += int'(dut.stall);
            flushes += int'(dut.flush);
        end
        chk("pending_writebacks", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        // load-use: lw then dependent add
        begin_test();
        dut.dmem[0] = 32'd5;
        dut.imem[0] = i_t(12'd0, 5'd0, 3'b010, 5'd1, 7'h03);
        dut.imem[1] = r_t(7'h00, 3'b000, 5'd2, 5'd1, 5'd1);
        expect_wb(5'd1, 32'd5);
        expect_wb(5'd2, 32'd10);
        run(12);
        chk("t1_stalls", stalls, 1);
        chk("t1_flushes", flushes, 0);
        chk("t1_x2", dut.regfile[2], 32'd10);

        // back-to-back forwarding plus remaining R-type ops
        begin_test();
        dut.regfile[4] = 32'h55;
        dut.imem[0] = addi(5'd1, 5'd0, 12'd3);
        dut.imem[1] = addi(5'd2, 5'd1, 12'd4);
        dut.imem[2] = r_t(7'h20, 3'b000, 5'd3, 5'd2, 5'd1);
        dut.imem[3] = r_t(7'h01, 3'b000, 5'd4, 5'd2, 5'd3);
        dut.imem[4] = r_t(7'h00, 3'b100, 5'd9, 5'd2, 5'd1);
        dut.imem[5] = r_t(7'h00, 3'b111, 5'd10, 5'd1, 5'd2);
        dut.imem[6] = r_t(7'h00, 3'b001, 5'd11, 5'd1, 5'd3);
        expect_wb(5'd1, 32'd3);
        expect_wb(5'd2, 32'd7);
        expect_wb(5'd3, 32'd4);
`ifdef PIPELINED_CPU_MUL_EN
        expect_wb(5'd4, 32'd28);
`endif
        expect_wb(5'd9, 32'd4);
        expect_wb(5'd10, 32'd3);
        expect_wb(5'd11, 32'd48);
        run(16);
        chk("t2_stalls", stalls, 0);
        chk("t2_x3", dut.regfile[3], 32'd4);
`ifdef PIPELINED_CPU_MUL_EN
        chk("t2_x4_mul", dut.regfile[4], 32'd28);
`else
        chk("t2_x4_mul_nop", dut.regfile[4], 32'h55);
`endif

        // taken beq skips the next instruction
        begin_test();
        br_target = 32'd20;
        dut.imem[0] = addi(5'd1, 5'd0, 12'd1);
        dut.imem[3] = beq(5'd1, 5'd1, 13'd8);
        dut.imem[4] = addi(5'd7, 5'd0, 12'd7);
        dut.imem[5] = addi(5'd8, 5'd0, 12'd8);
        expect_wb(5'd1, 32'd1);
        expect_wb(5'd8, 32'd8);
        run(14);
        chk("t3_flushes", flushes, 1);
        chk("t3_stalls", stalls, 0);
        chk("t3_x7_untouched", dut.regfile[7], 32'd0);
        chk("t3_x8", dut.regfile[8], 32'd8);

        // x0 immutability, store of zero, arithmetic shift
        begin_test();
        dut.dmem[1] = 32'hDEADBEEF;
        dut.imem[0] = addi(5'd0, 5'd0, 12'd9);
        dut.imem[1] = sw(5'd0, 5'd0, 12'd4);
        dut.imem[2] = addi(5'd5, 5'd0, 12'hFF8);
        dut.imem[3] = i_t({7'b0100000, 5'd1}, 5'd5, 3'b101, 5'd6, 7'h13);
        expect_wb(5'd5, 32'hFFFFFFF8);
        expect_wb(5'd6, 32'hFFFFFFFC);
        run(12);
        chk("t4_x0", dut.regfile[0], 32'd0);
        chk("t4_dmem1", dut.dmem[1], 32'd0);
        chk("t4_x6", dut.regfile[6], 32'hFFFFFFFC);

        // start_i hold, then reset mid-program
        begin_test();
        for (int i = 0; i < 8; i++) dut.imem[i] = addi(5'd0, 5'd0, 12'd1);
        chk("t5_reset_pc", dut.pc_q, 32'd0);
        chk("t5_reset_mem_wb_ctrl", {25'b0, dut.mem_wb.ctrl}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t5_hold_pc", dut.pc_q, 32'd0);
        end
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_running_pc", dut.pc_q, 32'd16);
        chk("t5_inflight_ctrl", {31'b0, dut.ex_mem.ctrl.reg_write}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_pc", dut.pc_q, 32'd0);
        chk("t5_rst_if_id", dut.if_id.instr, 32'd0);
        chk("t5_rst_id_ex_ctrl", {25'b0, dut.id_ex.ctrl}, 32'd0);
        chk("t5_rst_ex_mem_ctrl", {25'b0, dut.ex_mem.ctrl}, 32'd0);
        chk("t5_rst_mem_wb_ctrl", {25'b0, dut.mem_wb.ctrl}, 32'd0);
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
